eq_monitor: RTL and testbench
=============================

EQ_MONITOR -- requirements
Module: eq_monitor

Interface
REQ-001 Parameter WIDTH, default 8: number of compared outputs (per-output match bits) consumed.
REQ-002 Parameter WARMUP, default 4: cycles after reset during which comparisons are ignored.
REQ-003 Parameter RUN_LEN, default 1024: number of checked cycles before the run ends.
REQ-004 Parameter CNT_W, default 32: width of the cycle and mismatch counters.
REQ-005 Port: clk, input, 1, single clock; all logic on its rising edge.
REQ-006 Port: rst, input, 1, reset; synchronous, active-high.
REQ-007 Port: valid, input, 1, comparison inputs are meaningful this cycle (stimulus advanced).
REQ-008 Port: match, input, WIDTH, per-output equality bits from the equivalence top (1 = equal).
REQ-009 Port: trigger, input, 1, inverse-AND of match from the equivalence top.
REQ-010 Port: done, output, 1, run finished; also tells the upstream stimulus source to stop.
REQ-011 Port: fail, output, 1, sticky: at least one counted mismatch occurred.
REQ-012 Port: first_mask, output, WIDTH, ~match captured at the first counted mismatch.
REQ-013 Port: first_cycle, output, CNT_W, check-cycle index of the first counted mismatch.
REQ-014 Port: mismatch_cnt, output, CNT_W, number of counted mismatch cycles, saturating.

Function
REQ-015 FSM states: WARM, RUN, DONE. The FSM SHALL be in WARM after reset.
REQ-016 WARM: each valid cycle decrements the warmup counter; mismatches are ignored; move to RUN on the cycle the WARMUP-th valid is seen. WARMUP=0 goes straight to RUN.
REQ-017 RUN: each valid cycle is a check cycle. The check index starts at 0 and increments by 1 per valid. Cycles with valid=0 change no state or counters.
REQ-018 A check cycle is a mismatch when trigger=1 or any match bit is 0. A trigger/match disagreement also counts as a mismatch.
REQ-019 First mismatch in RUN: fail<=1; first_mask<=~match; first_cycle<=current check index, all on the next clock edge. Later mismatches SHALL NOT alter first_mask or first_cycle.
REQ-020 Every mismatch check cycle increments mismatch_cnt. The counter saturates at all-ones and does not wrap.
REQ-021 RUN moves to DONE after the RUN_LEN-th check cycle. That cycle is still evaluated, so done and that cycle's mismatch update appear on the same edge.
REQ-022 DONE is terminal until rst. done=1. valid, match and trigger are ignored and all outputs hold.
REQ-023 Latency: every output reflects an input sample one clock after the sampling edge. There are no combinational input-to-output paths.
REQ-024 The check index counts up to RUN_LEN-1 only, so the CNT_W index never wraps. RUN_LEN SHALL be < 2^CNT_W.

Reset
REQ-025 On rst=1 at a clock edge: state<=WARM, done<=0, fail<=0, first_mask<=0, first_cycle<=0, mismatch_cnt<=0, and both internal counters cleared/reloaded.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abandon the run fully. No captured value survives.
REQ-027 rst takes priority over valid in the same cycle.

Configuration
REQ-028 Macro EQ_MONITOR_STOP_ON_FAIL_EN.
  - Defined: the first counted mismatch moves RUN to DONE on the same edge that sets fail, so mismatch_cnt ends at 1.
  - Undefined: the run always lasts RUN_LEN check cycles and keeps counting mismatches.

Structure
REQ-029 A shared package eq_pkg SHALL hold the state enum type (WARM/RUN/DONE) and the default constants for WARMUP, RUN_LEN and CNT_W.
REQ-030 One sub-module, eq_sat_counter (parameterised width, increment enable, synchronous clear, saturate at max), SHALL implement mismatch_cnt. The remaining logic stays in eq_monitor.

Verification
REQ-031 WIDTH=8, WARMUP=4, RUN_LEN=16, all match=8'hFF, trigger=0, valid=1 continuously:
  - done rises on the 20th edge after reset release.
  - fail=0, mismatch_cnt=0.
REQ-032 match=8'h00 with trigger=1 during the 4 warmup cycles, all equal afterwards -> fail=0 at done.
REQ-033 Mismatch at check index 5 with match=8'hDF, plus another at index 9 with match=8'h7F (macro undefined):
  - first_mask=8'h20, first_cycle=5.
  - mismatch_cnt=2, done at check 15.
REQ-034 Same stimulus as REQ-033 with EQ_MONITOR_STOP_ON_FAIL_EN defined:
  - done=1 one edge after index 5.
  - mismatch_cnt=1; the index-9 mismatch is ignored.
REQ-035 valid toggling 1/0 every cycle with RUN_LEN=16 -> done after 20 valid cycles (40 clocks); counts unaffected by valid=0 cycles.
REQ-036 rst pulsed for one cycle at check index 8 after a mismatch at index 3 -> all outputs 0, state WARM; a clean rerun then ends with fail=0.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and default constants for the equivalence monitor.
package eq_pkg;

   typedef enum logic [1:0] {
      WARM = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } eq_state_t;

   localparam int DEF_WARMUP  = 4;
   localparam int DEF_RUN_LEN = 1024;
   localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/eq_sat_counter.sv
// Up-counter with increment enable and synchronous clear that sticks at all-ones.
module eq_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/eq_monitor.sv
// Equivalence-run monitor: warm-up, RUN_LEN checked cycles, first-mismatch capture.
// Build option: EQ_MONITOR_STOP_ON_FAIL_EN ends the run at the first counted mismatch.
module eq_monitor
   import eq_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int WARMUP  = DEF_WARMUP,
   parameter int RUN_LEN = DEF_RUN_LEN,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [WIDTH-1:0] match,
   input  logic             trigger,
   output logic             done,
   output logic             fail,
   output logic [WIDTH-1:0] first_mask,
   output logic [CNT_W-1:0] first_cycle,
   output logic [CNT_W-1:0] mismatch_cnt,
   output eq_state_t        state_dbg
);

   // valid qualifies match/trigger for one cycle; there is no ready because the
   // monitor never stalls. done is the only back-pressure: the source stops on it.

   localparam logic [CNT_W-1:0] WARM_INIT = CNT_W'(WARMUP);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(RUN_LEN - 1);

   eq_state_t        state_q, state_d;
   logic [CNT_W-1:0] warm_cnt_q;
   logic [CNT_W-1:0] check_idx_q;
   logic             check_cycle;
   logic             mismatch;
   logic             counted;
   logic             first_hit;
   logic             last_check;

   assign check_cycle = (state_q == RUN) && valid;
   // A trigger/match disagreement also lands here, since either term alone flags it.
   assign mismatch    = trigger || !(&match);
   assign counted     = check_cycle && mismatch;
   assign first_hit   = counted && !fail;
   assign last_check  = check_cycle && (check_idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      case (state_q)
         WARM: begin
            if (warm_cnt_q == '0) begin
               state_d = RUN;
            end else if (valid && (warm_cnt_q == CNT_W'(1))) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_check) begin
               state_d = DONE;
            end
`ifdef EQ_MONITOR_STOP_ON_FAIL_EN
            if (first_hit) begin
               state_d = DONE;
            end
`endif
         end
         DONE:    state_d = DONE;
         default: state_d = WARM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WARM;
         warm_cnt_q  <= WARM_INIT;
         check_idx_q <= '0;
         fail        <= 1'b0;
         first_mask  <= '0;
         first_cycle <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == WARM) && valid && (warm_cnt_q != '0)) begin
            warm_cnt_q <= warm_cnt_q - CNT_W'(1);
         end
         if (check_cycle && !last_check) begin
            check_idx_q <= check_idx_q + CNT_W'(1);
         end
         if (first_hit) begin
            fail        <= 1'b1;
            first_mask  <= ~match;
            first_cycle <= check_idx_q;
         end
      end
   end

   eq_sat_counter #(
      .W(CNT_W)
   ) u_mismatch_cnt (
      .clk  (clk),
      .clr  (rst),
      .inc  (counted),
      .count(mismatch_cnt)
   );

   assign done      = (state_q == DONE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_eq_monitor.sv
// Directed bench for eq_monitor (WIDTH=8, WARMUP=4, RUN_LEN=16) and its saturating counter.
module tb_eq_monitor;
   import eq_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [7:0]  match = 8'hFF;
   logic        trigger = 1'b0;
   logic        done;
   logic        fail;
   logic [7:0]  first_mask;
   logic [31:0] first_cycle;
   logic [31:0] mismatch_cnt;
   eq_state_t   state_dbg;

   logic        sc_clr = 1'b1;
   logic        sc_inc = 1'b0;
   logic [1:0]  sc_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   eq_monitor #(
      .WIDTH(8), .WARMUP(4), .RUN_LEN(16), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst), .valid(valid), .match(match), .trigger(trigger),
      .done(done), .fail(fail), .first_mask(first_mask), .first_cycle(first_cycle),
      .mismatch_cnt(mismatch_cnt), .state_dbg(state_dbg)
   );

   eq_sat_counter #(.W(2)) u_sat (
      .clk(clk), .clr(sc_clr), .inc(sc_inc), .count(sc_count)
   );

   // Drive one cycle of inputs, then sample 1 ns after the edge that consumed them.
   task automatic step(input logic v, input logic [7:0] m, input logic t);
      valid = v; match = m; trigger = t;
      @(posedge clk);
      #1;
   endtask

   // rst is held with a valid mismatching sample to show reset wins over valid.
   task automatic do_reset();
      rst = 1'b1;
      step(1'b1, 8'h00, 1'b1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b exp 0", fail); end
      checks++; if (first_mask !== 8'h00) begin errors++; $display("FAIL reset_mask got %h exp 00", first_mask); end
      checks++; if (first_cycle !== 32'd0) begin errors++; $display("FAIL reset_cycle got %0d exp 0", first_cycle); end
      checks++; if (mismatch_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", mismatch_cnt); end
      checks++; if (state_dbg !== WARM) begin errors++; $display("FAIL reset_state got %0d exp WARM", state_dbg); end
   endtask

   task automatic test_clean_run();
      int rise_edge;
      rise_edge = 0;
      do_reset();
      for (int i = 1; i <= 40; i++) begin
         step(1'b1, 8'hFF, 1'b0);
         if (done && rise_edge == 0) rise_edge = i;
      end
      checks++; if (rise_edge !== 20) begin errors++; $display("FAIL clean_done_edge got %0d exp 20", rise_edge); end
      checks++; if (fail !== 1'b0) begin errors++; $display("FAIL clean_fail got %b exp 0", fail); end
      checks++; if (mismatch_cnt !== 32'd0) begin errors++; $display("FAIL clean_cnt got %0d exp 0", mismatch_cnt); end
   endtask

   task automatic test_warmup_ignored();
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 1'b1);
      checks++; if (state_dbg !== RUN) begin errors++; $display("FAIL warm_to_run got %0d exp RUN", state_dbg); end
      for (int i = 0; i < 15; i++) step(1'b1, 8'hFF, 1'b0);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL warm_early_done got %b exp 0", done); end
      step(1'b1, 8'hFF, 1'b0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL warm_done got %b exp 1", done); end
      checks++; if (fail !== 1'b0) begin errors++; $display("FAIL warm_fail got %b exp 0", fail); end
      checks++; if (mismatch_cnt !== 32'd0) begin errors++; $display("FAIL warm_cnt got %0d exp 0", mismatch_cnt); end
   endtask

   task automatic test_mismatch();
      logic [7:0] m;
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 1'b0);
      for (int idx = 0; idx < 16; idx++) begin
         m = (idx == 5) ? 8'hDF : (idx == 9) ? 8'h7F : 8'hFF;
         step(1'b1, m, m != 8'hFF);
`ifdef EQ_MONITOR_STOP_ON_FAIL_EN
         if (idx == 4) begin
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_early_done got %b exp 0", done); end
         end
         if (idx == 5) begin
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL stop_done got %b exp 1", done); end
            checks++; if (mismatch_cnt !== 32'd1) begin errors++; $display("FAIL stop_cnt5 got %0d exp 1", mismatch_cnt); end
         end
`else
         if (idx == 14) begin
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL mm_early_done got %b exp 0", done); end
            checks++; if (mismatch_cnt !== 32'd2) begin errors++; $display("FAIL mm_cnt14 got %0d exp 2", mismatch_cnt); end
         end
         if (idx == 15) begin
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL mm_done got %b exp 1", done); end
         end
`endif
      end
      // Post-done mismatches must not move anything.
      for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b1);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL mm_done_hold got %b exp 1", done); end
      checks++; if (fail !== 1'b1) begin errors++; $display("FAIL mm_fail got %b exp 1", fail); end
      checks++; if (first_mask !== 8'h20) begin errors++; $display("FAIL mm_mask got %h exp 20", first_mask); end
      checks++; if (first_cycle !== 32'd5) begin errors++; $display("FAIL mm_cycle got %0d exp 5", first_cycle); end
`ifdef EQ_MONITOR_STOP_ON_FAIL_EN
      checks++; if (mismatch_cnt !== 32'd1) begin errors++; $display("FAIL stop_cnt got %0d exp 1", mismatch_cnt); end
`else
      checks++; if (mismatch_cnt !== 32'd2) begin errors++; $display("FAIL mm_cnt got %0d exp 2", mismatch_cnt); end
`endif
   endtask

   task automatic test_disagree();
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 1'b0);
      for (int idx = 0; idx < 16; idx++) begin
         if (idx == 2) step(1'b1, 8'hFF, 1'b1);
         else if (idx == 4) step(1'b1, 8'hFE, 1'b0);
         else step(1'b1, 8'hFF, 1'b0);
      end
      checks++; if (first_mask !== 8'h00) begin errors++; $display("FAIL dis_mask got %h exp 00", first_mask); end
      checks++; if (first_cycle !== 32'd2) begin errors++; $display("FAIL dis_cycle got %0d exp 2", first_cycle); end
`ifdef EQ_MONITOR_STOP_ON_FAIL_EN
      checks++; if (mismatch_cnt !== 32'd1) begin errors++; $display("FAIL dis_cnt got %0d exp 1", mismatch_cnt); end
`else
      checks++; if (mismatch_cnt !== 32'd2) begin errors++; $display("FAIL dis_cnt got %0d exp 2", mismatch_cnt); end
`endif
   endtask

   task automatic test_valid_toggle();
      int rise_clk;
      rise_clk = 0;
      do_reset();
      // Idle cycles carry a glaring mismatch that must be ignored.
      for (int i = 1; i <= 60; i++) begin
         if (i % 2 == 1) step(1'b0, 8'h00, 1'b1);
         else step(1'b1, 8'hFF, 1'b0);
         if (done && rise_clk == 0) rise_clk = i;
      end
      checks++; if (rise_clk !== 40) begin errors++; $display("FAIL tog_done_clk got %0d exp 40", rise_clk); end
      checks++; if (fail !== 1'b0) begin errors++; $display("FAIL tog_fail got %b exp 0", fail); end
      checks++; if (mismatch_cnt !== 32'd0) begin errors++; $display("FAIL tog_cnt got %0d exp 0", mismatch_cnt); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 1'b0);
      for (int idx = 0; idx < 8; idx++) begin
         if (idx == 3) step(1'b1, 8'hF7, 1'b1);
         else step(1'b1, 8'hFF, 1'b0);
      end
      checks++; if (fail !== 1'b1) begin errors++; $display("FAIL mid_pre_fail got %b exp 1", fail); end
      do_reset();
      checks++; if (state_dbg !== WARM) begin errors++; $display("FAIL mid_state got %0d exp WARM", state_dbg); end
      checks++; if (fail !== 1'b0) begin errors++; $display("FAIL mid_fail got %b exp 0", fail); end
      checks++; if (first_mask !== 8'h00) begin errors++; $display("FAIL mid_mask got %h exp 00", first_mask); end
      checks++; if (first_cycle !== 32'd0) begin errors++; $display("FAIL mid_cycle got %0d exp 0", first_cycle); end
      checks++; if (mismatch_cnt !== 32'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", mismatch_cnt); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b exp 0", done); end
      for (int i = 0; i < 20; i++) step(1'b1, 8'hFF, 1'b0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rerun_done got %b exp 1", done); end
      checks++; if (fail !== 1'b0) begin errors++; $display("FAIL rerun_fail got %b exp 0", fail); end
      // Reset from DONE must also clear everything.
      do_reset();
      checks++; if (state_dbg !== WARM) begin errors++; $display("FAIL done_rst_state got %0d exp WARM", state_dbg); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_rst_done got %b exp 0", done); end
   endtask

   task automatic test_saturation();
      sc_clr = 1'b1; sc_inc = 1'b0;
      @(posedge clk); #1;
      sc_clr = 1'b0; sc_inc = 1'b1;
      for (int i = 0; i < 2; i++) begin @(posedge clk); #1; end
      checks++; if (sc_count !== 2'd2) begin errors++; $display("FAIL sat_mid got %0d exp 2", sc_count); end
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      checks++; if (sc_count !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", sc_count); end
      sc_inc = 1'b0; sc_clr = 1'b1;
      @(posedge clk); #1;
      checks++; if (sc_count !== 2'd0) begin errors++; $display("FAIL sat_clr got %0d exp 0", sc_count); end
      sc_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_warmup_ignored();
      test_mismatch();
      test_disagree();
      test_valid_toggle();
      test_reset_mid_run();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
